// File: rtl/pci_intr_pkg.sv
// Shared types and helpers for the PCI interrupt controller.
// The FSM state enum, the MSI vector-mask helper and the MME clamp limit live here.
package pci_intr_pkg;

   typedef enum logic [0:0] {
      IDLE,
      ISSUE
   } intr_state_t;

   // Largest Multiple Message Enable value accepted (32 vectors).
   localparam logic [2:0] MSI_MME_MAX = 3'd5;

   function automatic logic [15:0] msi_vec_mask(input logic [2:0] mme);
      logic [2:0] mme_c;
      mme_c = (mme > MSI_MME_MAX) ? MSI_MME_MAX : mme;
      return (16'd1 << mme_c) - 16'd1;
   endfunction

endpackage

// File: rtl/pci_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr wins.
// The search wraps at NUM_SRC.
module pci_rr_arbiter #(
   parameter int unsigned NUM_SRC   = 4,
   parameter int unsigned SRC_IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic [NUM_SRC-1:0]   req,
   input  logic [SRC_IDX_W-1:0] ptr,
   output logic [SRC_IDX_W-1:0] idx,
   output logic                 valid
);

   always_comb begin
      int unsigned           cand;
      logic [SRC_IDX_W-1:0]  cand_idx;
      idx      = '0;
      valid    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         cand     = (32'(ptr) + i) % NUM_SRC;
         cand_idx = SRC_IDX_W'(cand);
         if (!valid && req[cand_idx]) begin
            valid = 1'b1;
            idx   = cand_idx;
         end
      end
   end

endmodule

// File: rtl/pci_intr_ctrl.sv
// PCI interrupt controller: edge-latched pending bits, round-robin MSI delivery or legacy INTA#.
// Define PCI_INTR_MASK_EN to add the irq_mask input that hides sources from arbitration/status.
module pci_intr_ctrl
   import pci_intr_pkg::*;
#(
   parameter int unsigned NUM_SRC   = 4,
   parameter int unsigned SRC_IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic [NUM_SRC-1:0] irq_clear,
   output logic [NUM_SRC-1:0] irq_pending,
`ifdef PCI_INTR_MASK_EN
   input  logic [NUM_SRC-1:0] irq_mask,
`endif
   input  logic               msi_enable,
   input  logic [2:0]         msi_multiple_message,
   input  logic [63:0]        msi_address,
   input  logic [15:0]        msi_data,
   input  logic               command_intr_disable,
   input  logic               command_bus_master,
   output logic               msi_req,
   output logic [63:0]        msi_req_addr,
   output logic [31:0]        msi_req_data,
   input  logic               msi_ack,
   input  logic               msi_err,
   output logic               intr_status,
   output logic               inta_assert
);

   intr_state_t          state_q, state_d;
   logic [NUM_SRC-1:0]   src_q;
   logic [NUM_SRC-1:0]   pending_q, pending_d;
   logic [NUM_SRC-1:0]   src_event;
   logic [NUM_SRC-1:0]   eligible;
   logic [NUM_SRC-1:0]   ack_clr;
   logic [SRC_IDX_W-1:0] ptr_q, ptr_d;
   logic [SRC_IDX_W-1:0] win_q, win_d;
   logic [SRC_IDX_W-1:0] win_next;
   logic [SRC_IDX_W-1:0] arb_idx;
   logic                 arb_valid;
   logic [63:0]          addr_q, addr_d;
   logic [31:0]          data_q, data_d;
   logic [15:0]          vmask;
   logic [15:0]          win_ext;
   logic                 intr_status_q;
   logic                 inta_q;

   assign src_event = irq_src & ~src_q;

`ifdef PCI_INTR_MASK_EN
   assign eligible = pending_q & ~irq_mask;
`else
   assign eligible = pending_q;
`endif

   pci_rr_arbiter #(
      .NUM_SRC   (NUM_SRC),
      .SRC_IDX_W (SRC_IDX_W)
   ) u_arb (
      .req   (eligible),
      .ptr   (ptr_q),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   assign vmask    = msi_vec_mask(msi_multiple_message);
   assign win_ext  = 16'(arb_idx);
   assign win_next = (win_q == SRC_IDX_W'(NUM_SRC - 1)) ? '0 : win_q + 1'b1;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      addr_d  = addr_q;
      data_d  = data_q;
      ack_clr = '0;
      case (state_q)
         IDLE: begin
            if (msi_enable && command_bus_master && arb_valid) begin
               win_d   = arb_idx;
               addr_d  = {msi_address[63:2], 2'b00};
               data_d  = {16'h0000, (msi_data & ~vmask) | (win_ext & vmask)};
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // An abort wins over a simultaneous ack so the event is retried.
            if (msi_err) begin
               ptr_d   = win_next;
               state_d = IDLE;
            end else if (msi_ack) begin
               ack_clr[win_q] = 1'b1;
               ptr_d          = win_next;
               state_d        = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A fresh edge always beats either form of clear in the same cycle.
   assign pending_d = (pending_q & ~(irq_clear | ack_clr)) | src_event;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         src_q         <= '0;
         pending_q     <= '0;
         ptr_q         <= '0;
         win_q         <= '0;
         addr_q        <= '0;
         data_q        <= '0;
         intr_status_q <= 1'b0;
         inta_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         src_q         <= irq_src;
         pending_q     <= pending_d;
         ptr_q         <= ptr_d;
         win_q         <= win_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         intr_status_q <= |eligible;
         inta_q        <= intr_status_q & ~command_intr_disable & ~msi_enable;
      end
   end

   assign irq_pending  = pending_q;
   assign msi_req      = (state_q == ISSUE);
   assign msi_req_addr = addr_q;
   assign msi_req_data = data_q;
   assign intr_status  = intr_status_q;
   assign inta_assert  = inta_q;

endmodule

// File: tb/tb_pci_intr_ctrl.sv
// Directed bench for pci_intr_ctrl: expected MSI writes are queued by the stimulus and
// checked by a monitor on each new request; status/pending checks are made inline.
module tb_pci_intr_ctrl;

   typedef struct packed {
      logic [63:0] addr;
      logic [31:0] data;
   } msi_exp_t;

   localparam logic [63:0] MSI_A = 64'h0000_0001_FEE0_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  irq_src = '0;
   logic [3:0]  irq_clear = '0;
   logic [3:0]  irq_pending;
   logic        msi_enable = 1'b0;
   logic [2:0]  msi_multiple_message = '0;
   logic [63:0] msi_address = '0;
   logic [15:0] msi_data = '0;
   logic        command_intr_disable = 1'b0;
   logic        command_bus_master = 1'b0;
   logic        msi_req;
   logic [63:0] msi_req_addr;
   logic [31:0] msi_req_data;
   logic        msi_ack = 1'b0;
   logic        msi_err = 1'b0;
   logic        intr_status;
   logic        inta_assert;

   int n_pass  = 0;
   int n_total = 0;
   msi_exp_t exp_q[$];
   logic req_prev = 1'b0;

   always #5 clk = ~clk;

   pci_intr_ctrl #(
      .NUM_SRC (4)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .irq_src              (irq_src),
      .irq_clear            (irq_clear),
      .irq_pending          (irq_pending),
`ifdef PCI_INTR_MASK_EN
      .irq_mask             (4'b0000),
`endif
      .msi_enable           (msi_enable),
      .msi_multiple_message (msi_multiple_message),
      .msi_address          (msi_address),
      .msi_data             (msi_data),
      .command_intr_disable (command_intr_disable),
      .command_bus_master   (command_bus_master),
      .msi_req              (msi_req),
      .msi_req_addr         (msi_req_addr),
      .msi_req_data         (msi_req_data),
      .msi_ack              (msi_ack),
      .msi_err              (msi_err),
      .intr_status          (intr_status),
      .inta_assert          (inta_assert)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      else n_pass++;
   endtask

   // Monitor: every new MSI request is matched against the head of the queue.
   always @(negedge clk) begin
      if (msi_req && !req_prev) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL msi_unexpected: got addr %0h data %0h, expected no request",
                     msi_req_addr, msi_req_data);
         end else begin
            msi_exp_t e;
            e = exp_q.pop_front();
            chk("msi_addr", msi_req_addr, e.addr);
            chk("msi_data", 64'(msi_req_data), 64'(e.data));
         end
      end
      req_prev = msi_req;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_src(input logic [3:0] m);
      irq_src = m;
      tick(1);
      irq_src = '0;
   endtask

   task automatic push_exp(input logic [31:0] d);
      msi_exp_t e;
      e.addr = MSI_A;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic wait_req();
      int k;
      k = 0;
      while (!msi_req && k < 20) begin
         tick(1);
         k++;
      end
      if (!msi_req) begin
         n_total++;
         $display("FAIL wait_req: got no msi_req within 20 cycles, expected a request");
      end
   endtask

   task automatic respond(input logic ack, input logic err);
      msi_ack = ack;
      msi_err = err;
      tick(1);
      msi_ack = 1'b0;
      msi_err = 1'b0;
   endtask

   initial begin
      tick(2);
      rst = 1'b0;
      chk("rst_pending", 64'(irq_pending), 64'h0);
      chk("rst_req", 64'(msi_req), 64'h0);
      chk("rst_addr", msi_req_addr, 64'h0);
      chk("rst_data", 64'(msi_req_data), 64'h0);
      chk("rst_status", 64'(intr_status), 64'h0);
      chk("rst_inta", 64'(inta_assert), 64'h0);

      // Legacy INTx path
      pulse_src(4'b0100);
      chk("intx_pending", 64'(irq_pending), 64'h4);
      tick(1);
      chk("intx_status", 64'(intr_status), 64'h1);
      chk("intx_inta_lag", 64'(inta_assert), 64'h0);
      tick(1);
      chk("intx_inta", 64'(inta_assert), 64'h1);
      command_intr_disable = 1'b1;
      tick(1);
      chk("intx_disable_inta", 64'(inta_assert), 64'h0);
      chk("intx_disable_status", 64'(intr_status), 64'h1);
      irq_clear = 4'b0100;
      tick(1);
      irq_clear = '0;
      chk("intx_clear_pending", 64'(irq_pending), 64'h0);
      tick(1);
      chk("intx_clear_status", 64'(intr_status), 64'h0);
      command_intr_disable = 1'b0;

      // Single MSI; address bits [1:0] must be dropped
      msi_enable           = 1'b1;
      command_bus_master   = 1'b1;
      msi_address          = 64'h0000_0001_FEE0_0003;
      msi_data             = 16'h4020;
      msi_multiple_message = 3'd0;
      push_exp(32'h0000_4020);
      pulse_src(4'b0010);
      wait_req();
      respond(1'b1, 1'b0);
      chk("single_pending", 64'(irq_pending), 64'h0);
      chk("single_req_drop", 64'(msi_req), 64'h0);

      // Round robin with 4 vectors from a reset pointer
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      msi_multiple_message = 3'd2;
      push_exp(32'h0000_4020);
      push_exp(32'h0000_4023);
      pulse_src(4'b1001);
      wait_req();
      respond(1'b1, 1'b0);
      chk("rr_idle_gap", 64'(msi_req), 64'h0);
      chk("rr_pending_mid", 64'(irq_pending), 64'h8);
      wait_req();
      respond(1'b1, 1'b0);
      chk("rr_pending_done", 64'(irq_pending), 64'h0);
      // Pointer wrapped to 0, so src0 precedes src1
      push_exp(32'h0000_4020);
      push_exp(32'h0000_4021);
      pulse_src(4'b0011);
      wait_req();
      respond(1'b1, 1'b0);
      wait_req();
      respond(1'b1, 1'b0);
      chk("wrap_pending", 64'(irq_pending), 64'h0);

      // Abort and retry on src2
      push_exp(32'h0000_4022);
      push_exp(32'h0000_4022);
      push_exp(32'h0000_4022);
      pulse_src(4'b0100);
      wait_req();
      respond(1'b0, 1'b1);
      chk("err_pending_kept", 64'(irq_pending), 64'h4);
      chk("err_idle_gap", 64'(msi_req), 64'h0);
      tick(1);
      chk("err_reissue", 64'(msi_req), 64'h1);
      respond(1'b1, 1'b1);
      chk("ackerr_pending_kept", 64'(irq_pending), 64'h4);
      wait_req();
      respond(1'b1, 1'b0);
      chk("err_final_pending", 64'(irq_pending), 64'h0);

      // Request held while enables drop
      push_exp(32'h0000_4020);
      pulse_src(4'b0001);
      wait_req();
      msi_enable         = 1'b0;
      command_bus_master = 1'b0;
      tick(3);
      chk("hold_req", 64'(msi_req), 64'h1);
      chk("hold_addr", msi_req_addr, MSI_A);
      chk("hold_data", 64'(msi_req_data), 64'h4020);
      respond(1'b1, 1'b0);
      chk("hold_pending", 64'(irq_pending), 64'h0);
      chk("hold_req_drop", 64'(msi_req), 64'h0);
      msi_enable         = 1'b1;
      command_bus_master = 1'b1;

      // Reset aborts an outstanding request
      push_exp(32'h0000_4021);
      pulse_src(4'b0010);
      wait_req();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("rst_mid_req", 64'(msi_req), 64'h0);
      chk("rst_mid_pending", 64'(irq_pending), 64'h0);
      chk("rst_mid_addr", msi_req_addr, 64'h0);

      // New edge beats irq_clear
      msi_enable = 1'b0;
      pulse_src(4'b0100);
      tick(1);
      irq_src   = 4'b0100;
      irq_clear = 4'b0100;
      tick(1);
      irq_src   = '0;
      irq_clear = '0;
      chk("race_clear", 64'(irq_pending), 64'h4);
      irq_clear = 4'b0100;
      tick(1);
      irq_clear = '0;
      chk("race_clear_after", 64'(irq_pending), 64'h0);

      // New edge beats MSI ack clear
      msi_enable = 1'b1;
      tick(1);
      push_exp(32'h0000_4022);
      push_exp(32'h0000_4022);
      pulse_src(4'b0100);
      wait_req();
      irq_src = 4'b0100;
      respond(1'b1, 1'b0);
      irq_src = '0;
      chk("race_ack", 64'(irq_pending), 64'h4);
      wait_req();
      respond(1'b1, 1'b0);
      chk("race_ack_after", 64'(irq_pending), 64'h0);

      tick(3);
      chk("exp_queue_empty", 64'(exp_q.size()), 64'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pci_intr_ctrl.md
Name: pci_intr_ctrl

Overview:
- Interrupt controller that sits between device interrupt sources and the PCI configuration/master logic.
- Latches edge events from N sources into pending bits and schedules them round-robin.
- When MSI is enabled, issues MSI memory-write requests to the bus-master engine; otherwise drives legacy INTA# and the config-space Interrupt Status bit.
- Consumes the MSI and Command register fields exported by the config-space block.

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..32)
- SRC_IDX_W, $clog2(NUM_SRC) (min 1), source index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- irq_src  in  NUM_SRC  per-source interrupt lines, rising edge = event
- irq_clear  in  NUM_SRC  write-1-to-clear pending strobe from device register file
- irq_pending  out  NUM_SRC  pending bits
- msi_enable  in  1  MSI Control enable bit
- msi_multiple_message  in  3  MSI Multiple Message Enable (log2 vectors granted)
- msi_address  in  64  MSI address, bits [1:0] ignored
- msi_data  in  16  MSI data base value
- command_intr_disable  in  1  Command bit 10
- command_bus_master  in  1  Command bit 2
- msi_req  out  1  MSI write request to master engine
- msi_req_addr  out  64  MSI write address
- msi_req_data  out  32  MSI write data
- msi_ack  in  1  master write completed
- msi_err  in  1  master write aborted (master/target abort)
- intr_status  out  1  Status bit 3 source
- inta_assert  out  1  drive INTA# low when 1

Behaviour:
- Reset (synchronous, next edge with rst=1): irq_pending=0, msi_req=0, msi_req_addr=0, msi_req_data=0, inta_assert=0, intr_status=0, RR pointer=0, FSM=IDLE, irq_src edge-detect history=0.
- Edge detect: irq_src registered once; event = src & ~src_q. The pending bit sets on the cycle after the event.
- Set/clear priority:
  - set wins over irq_clear and over MSI-delivery clear in the same cycle;
  - irq_clear on a non-pending bit is a no-op.
- intr_status = |irq_pending (registered). It is independent of intr_disable, per PCI.
- inta_assert = intr_status & ~command_intr_disable & ~msi_enable (registered, 1-cycle lag).
- FSM states:
  - IDLE: if msi_enable & command_bus_master & |irq_pending, select the winner round-robin starting at the RR pointer, capture index → ISSUE.
  - ISSUE: msi_req=1; hold addr/data stable until msi_ack or msi_err.
    - ack: clear the winner's pending bit, pointer = winner+1 (wrap at NUM_SRC) → IDLE.
    - err: pending bit kept, pointer = winner+1 → IDLE.
    - ack and err together: treated as err.
- MSI address/data formation, latched on entry to ISSUE:
  - msi_req_addr = {msi_address[63:2],2'b00}.
  - Vector mask m = (1<<msi_multiple_message)-1, with msi_multiple_message clamped to 5.
  - msi_req_data = {16'h0000, (msi_data & ~m) | (winner & m)}.
- Minimum spacing between MSIs is one IDLE cycle, so each message costs ≥2 cycles plus master latency.
- Once msi_req is raised it is never withdrawn before ack/err, even if msi_enable, command_bus_master or command_intr_disable drop. Only rst aborts it, on the next edge.
- In INTx mode (msi_enable=0), pending is cleared only by irq_clear.
- On an msi_enable 0→1 transition, already-pending bits are delivered as MSIs.

Optional Feature:
- Macro: PCI_INTR_MASK_EN.
- Defined:
  - adds input port irq_mask[NUM_SRC-1:0] (1 = masked);
  - masked sources still latch pending but are excluded from arbitration, intr_status and inta_assert;
  - unmasking a pending source makes it eligible next cycle.
- Undefined: no port; all sources always eligible.

Decomposition:
- Package pci_intr_pkg:
  - FSM enum intr_state_t {IDLE, ISSUE};
  - MSI vector-mask function msi_vec_mask(mme);
  - clamp constant MSI_MME_MAX=5.
- Sub-module pci_rr_arbiter: parameterised NUM_SRC; combinational grant from request vector + pointer, output index and valid. Reused later by the DMA channel scheduler.

Test Plan:
- Reset: after rst, all outputs 0; pulse irq_src[2] with msi_enable=0 → irq_pending=4'b0100 two cycles later, intr_status=1, inta_assert=1; set command_intr_disable=1 → inta_assert=0, intr_status stays 1; irq_clear=4'b0100 → both 0.
- MSI single:
  - setup: msi_enable=1, command_bus_master=1, msi_address=64'h0000_0001_FEE0_0003, msi_data=16'h4020, mme=0;
  - event on src1 → msi_req=1, addr=64'h0000_0001_FEE0_0000, data=32'h0000_4020;
  - ack → pending[1]=0, msi_req=0.
- Round-robin/multi-vector:
  - setup: mme=2, msi_data=16'h4020; events on src0,src3 in the same cycle;
  - required: src0 delivered first with data 32'h4020, then src3 with data 32'h4023; pointer wraps to 0.
- Abort: msi_err on first request → pending bit retained, request re-issued after one IDLE cycle; simultaneous ack+err treated as err.
- Hold/reset: drop msi_enable and command_bus_master while msi_req=1 → req held until ack; assert rst mid-ISSUE → msi_req=0 next edge, pending cleared.
- Set-vs-clear race: new edge on src2 in the same cycle as irq_clear[2] or MSI ack for src2 → pending[2] remains 1.
